// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the SPI LCD write path
package lcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} lcd_state_e;
  localparam logic DC_CMD = 1'b0;
  localparam logic DC_DATA = 1'b1;
  localparam int LCD_WORD_W = 9;
endpackage

// File: rtl/lcd_spi_bit_timer.sv
// lcd_spi_bit_timer: SCLK phase generator with rise/fall strobes for the next edge
module lcd_spi_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk_50MHz,
  input  logic sys_rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic wrap;
  assign wrap = en && div_cnt == DW'(CLK_DIV - 1);
  assign rise = wrap & ~sclk;
  assign fall = wrap & sclk;
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst || !en) begin
      div_cnt <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: 9-bit word to 4-wire SPI (mode 0) serialiser with one-entry holding register
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 1,
  parameter int WORD_W = LCD_WORD_W
) (
  input  logic              sys_clk_50MHz,
  input  logic              sys_rst,
  input  logic [WORD_W-1:0] data,
  input  logic              en_write,
  output logic              wr_done,
  output logic              busy,
  output logic              overflow,
  output logic              lcd_cs,
  output logic              lcd_dc,
  output logic              lcd_sclk,
  output logic              lcd_mosi
);
  localparam int HW = CS_HOLD > 1 ? $clog2(CS_HOLD) : 1;
  lcd_state_e state;
  logic hold_full;
  logic [WORD_W-1:0] hold_word, src;
  logic [6:0] sh;
  logic [2:0] bit_cnt;
  logic last;
  logic [HW-1:0] hold_cnt;
  logic rise, fall;
  assign src = hold_full ? hold_word : data;
  lcd_spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .sys_clk_50MHz(sys_clk_50MHz),
    .sys_rst(sys_rst),
    .en(state == SHIFT),
    .sclk(lcd_sclk),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state <= IDLE;
      lcd_cs <= 1'b1;
      lcd_dc <= 1'b0;
      lcd_mosi <= 1'b0;
      wr_done <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
      hold_full <= 1'b0;
      hold_word <= '0;
      sh <= '0;
      bit_cnt <= '0;
      last <= 1'b0;
      hold_cnt <= '0;
    end else begin
      wr_done <= 1'b0;
      if (state != IDLE && en_write) begin
        if (hold_full) overflow <= 1'b1;
        else begin
          hold_full <= 1'b1;
          hold_word <= data;
        end
      end
      case (state)
        IDLE: begin
          if (hold_full || en_write) begin
            state <= SHIFT;
            lcd_cs <= 1'b0;
            busy <= 1'b1;
            lcd_dc <= src[WORD_W-1];
            lcd_mosi <= src[7];
            sh <= src[6:0];
            bit_cnt <= 3'd7;
            last <= 1'b0;
            // a held word leaving frees the slot for a same-cycle write
            hold_full <= hold_full && en_write;
            if (hold_full && en_write) hold_word <= data;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (rise) last <= bit_cnt == 3'd0;
          if (fall) begin
            if (last) begin
              state <= HOLD;
              hold_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              lcd_mosi <= sh[6];
              sh <= {sh[5:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(CS_HOLD - 1)) begin
            state <= IDLE;
            lcd_cs <= 1'b1;
            wr_done <= 1'b1;
            busy <= hold_full | en_write;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_spi_writer.sv
// tb_lcd_spi_writer: directed and randomized checks of lcd_spi_writer against a bus monitor and timing model
module tb_lcd_spi_writer;
  typedef struct {
    logic [8:0] w;
    int nb;
    int low;
    int fr;
    int lr;
  } frame_t;
  logic clk = 1'b0;
  logic rst, en, sel;
  logic [8:0] data;
  logic done1, busy1, ovf1, cs1, dc1, sclk1, mosi1;
  logic done6, busy6, ovf6, cs6, dc6, sclk6, mosi6;
  logic m_done, m_busy, m_ovf, m_cs, m_dc, m_sclk, m_mosi;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int bus_err = 0;
  frame_t frame_q[$];
  int done_q[$];
  logic p_cs = 1'b1, p_sclk = 1'b0, fdc = 1'b0;
  logic [7:0] acc = '0;
  int nb = 0, lowc = 0, fr = -1, lr = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_spi_writer dut (
    .sys_clk_50MHz(clk), .sys_rst(rst), .data(data), .en_write(en & ~sel),
    .wr_done(done1), .busy(busy1), .overflow(ovf1),
    .lcd_cs(cs1), .lcd_dc(dc1), .lcd_sclk(sclk1), .lcd_mosi(mosi1)
  );
  lcd_spi_writer #(.CLK_DIV(1), .CS_HOLD(3)) dut6 (
    .sys_clk_50MHz(clk), .sys_rst(rst), .data(data), .en_write(en & sel),
    .wr_done(done6), .busy(busy6), .overflow(ovf6),
    .lcd_cs(cs6), .lcd_dc(dc6), .lcd_sclk(sclk6), .lcd_mosi(mosi6)
  );

  assign m_done = sel ? done6 : done1;
  assign m_busy = sel ? busy6 : busy1;
  assign m_ovf  = sel ? ovf6 : ovf1;
  assign m_cs   = sel ? cs6 : cs1;
  assign m_dc   = sel ? dc6 : dc1;
  assign m_sclk = sel ? sclk6 : sclk1;
  assign m_mosi = sel ? mosi6 : mosi1;

  // bus monitor: decodes each CS-low window into a word plus its SCLK timing
  always @(negedge clk) begin
    if (m_done === 1'b1) done_q.push_back(cyc);
    if (m_cs === 1'b0) begin
      if (p_cs === 1'b1) begin
        if (m_sclk !== 1'b0) bus_err <= bus_err + 1;
        fdc <= m_dc;
        acc <= '0;
        nb <= 0;
        lowc <= 1;
        fr <= -1;
        lr <= -1;
      end else begin
        lowc <= lowc + 1;
        if (m_dc !== fdc) bus_err <= bus_err + 1;
        if (m_sclk === 1'b1 && p_sclk === 1'b0) begin
          acc <= {acc[6:0], m_mosi};
          nb <= nb + 1;
          if (fr < 0) fr <= cyc;
          lr <= cyc;
        end
      end
    end else if (m_cs === 1'b1 && p_cs === 1'b0) begin
      if (m_sclk !== 1'b0) bus_err <= bus_err + 1;
      frame_q.push_back('{w: {fdc, acc}, nb: nb, low: lowc, fr: fr, lr: lr});
    end
    p_cs <= m_cs;
    p_sclk <= m_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [8:0] w);
    data = w;
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (m_busy !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("drain_timeout", 32'(k < budget), 1);
    tick(2);
  endtask

  task automatic chk_frame(input logic [8:0] w, input int t, input int d, input int ch);
    frame_t f;
    int dn;
    chk("frame_present", 32'(frame_q.size() > 0), 1);
    if (frame_q.size() == 0) return;
    f = frame_q.pop_front();
    chk("frame_word", 32'(f.w), 32'(w));
    chk("frame_bits", f.nb, 8);
    chk("cs_low_cycles", f.low, 16 * d + ch);
    chk("first_rise", f.fr, t + 1 + d);
    chk("rise_span", f.lr - f.fr, 14 * d);
    chk("done_present", 32'(done_q.size() > 0), 1);
    if (done_q.size() == 0) return;
    dn = done_q.pop_front();
    chk("wr_done_cycle", dn, t + 1 + 16 * d + ch);
  endtask

  initial begin
    int t, low, cs34, cs35;
    int last_start, last_done;
    logic exp_ovf;
    logic [8:0] exp_w[$];
    int exp_s[$];
    rst = 1'b0; en = 1'b0; sel = 1'b0; data = '0;
    tick(2);
    do_reset();
    chk("rst_cs", 32'(cs1), 1);
    chk("rst_sclk", 32'(sclk1), 0);
    chk("rst_mosi", 32'(mosi1), 0);
    chk("rst_dc", 32'(dc1), 0);
    chk("rst_wr_done", 32'(done1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_overflow", 32'(ovf1), 0);
    tick(2);
    frame_q.delete(); done_q.delete();

    // command frame
    t = cyc;
    issue(9'h011);
    chk("cmd_start_cs", 32'(cs1), 0);
    chk("cmd_start_dc", 32'(dc1), 0);
    chk("cmd_start_mosi", 32'(mosi1), 0);
    chk("cmd_start_sclk", 32'(sclk1), 0);
    drain(100);
    chk_frame(9'h011, t, 2, 1);
    chk("cmd_extra_done", done_q.size(), 0);

    // data frame
    t = cyc;
    issue(9'h1A5);
    chk("data_start_dc", 32'(dc1), 1);
    chk("data_start_mosi", 32'(mosi1), 1);
    drain(100);
    chk_frame(9'h1A5, t, 2, 1);
    chk("data_bus_err", bus_err, 0);

    // back-to-back through the holding register
    t = cyc;
    issue(9'h12C);
    low = 0; cs34 = -1; cs35 = -1;
    while (cyc < t + 68) begin
      if (cyc == t + 5) begin data = 9'h1FF; en = 1'b1; end else en = 1'b0;
      if (busy1 !== 1'b1) low++;
      if (cyc == t + 34) cs34 = int'(cs1);
      if (cyc == t + 35) cs35 = int'(cs1);
      tick(1);
    end
    en = 1'b0;
    chk("b2b_busy_low_cycles", low, 0);
    chk("b2b_cs_at_done", cs34, 1);
    chk("b2b_cs_restart", cs35, 0);
    drain(100);
    chk_frame(9'h12C, t, 2, 1);
    chk_frame(9'h1FF, t + 34, 2, 1);
    chk("b2b_overflow", 32'(ovf1), 0);

    // overflow on a third back-to-back write
    t = cyc;
    issue(9'h001);
    issue(9'h002);
    chk("ovf_before", 32'(ovf1), 0);
    issue(9'h003);
    chk("ovf_set", 32'(ovf1), 1);
    drain(200);
    chk_frame(9'h001, t, 2, 1);
    chk_frame(9'h002, t + 34, 2, 1);
    chk("ovf_frames_left", frame_q.size(), 0);
    chk("ovf_done_left", done_q.size(), 0);
    chk("ovf_sticky", 32'(ovf1), 1);

    // reset mid-frame
    t = cyc;
    issue(9'h155);
    tick(t + 10 - cyc);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_cs", 32'(cs1), 1);
    chk("mrst_sclk", 32'(sclk1), 0);
    chk("mrst_busy", 32'(busy1), 0);
    chk("mrst_overflow", 32'(ovf1), 0);
    tick(40);
    chk("mrst_no_done", done_q.size(), 0);
    frame_q.delete();
    t = cyc;
    issue(9'h036);
    drain(100);
    chk_frame(9'h036, t, 2, 1);

    // CLK_DIV=1, CS_HOLD=3 instance
    sel = 1'b1;
    tick(2);
    frame_q.delete(); done_q.delete();
    t = cyc;
    issue(9'h0FF);
    chk("p6_start_mosi", 32'(mosi6), 1);
    chk("p6_start_cs", 32'(cs6), 0);
    drain(60);
    chk_frame(9'h0FF, t, 1, 3);
    chk("p6_bus_err", bus_err, 0);
    sel = 1'b0;
    tick(2);

    // randomized words and gaps against an arithmetic timing model
    do_reset();
    tick(2);
    frame_q.delete(); done_q.delete();
    last_start = -1000; last_done = -1000; exp_ovf = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [8:0] w;
      int gap, s;
      w = 9'($urandom);
      gap = int'($urandom_range(0, 45));
      t = cyc;
      if (t >= last_start) begin
        s = t > last_done ? t : last_done;
        exp_w.push_back(w);
        exp_s.push_back(s);
        last_start = s;
        last_done = s + 34;
      end else begin
        exp_ovf = 1'b1;
      end
      issue(w);
      tick(gap);
    end
    drain(200);
    chk("rnd_frame_count", frame_q.size(), exp_w.size());
    while (exp_w.size() > 0) chk_frame(exp_w.pop_front(), exp_s.pop_front(), 2, 1);
    chk("rnd_overflow", 32'(ovf1), 32'(exp_ovf));
    chk("rnd_done_left", done_q.size(), 0);
    chk("rnd_bus_err", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
